// File: rtl/frac_clk_enable_gen.sv
// Multi-channel fractional clock-enable generator (NUM pulses per DEN clocks).
// Optional packed burst pattern when CLK_EN_BURST_MODE_EN is defined.
module frac_clk_enable_gen #(
  parameter int NUM_CH  = 2,
  parameter int RATIO_W = 8,
  parameter int DEF_NUM = 2,
  parameter int DEF_DEN = 3,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [RATIO_W-1:0] cfg_num,
  input  logic [RATIO_W-1:0] cfg_den,
  input  logic               cfg_burst,
  output logic               cfg_err,
  output logic [NUM_CH-1:0]  clk_enable,
  output logic [NUM_CH-1:0]  period_start
);

  logic [RATIO_W-1:0] num_q  [NUM_CH];
  logic [RATIO_W-1:0] den_q  [NUM_CH];
  logic [RATIO_W-1:0] acc_q  [NUM_CH];
  logic [RATIO_W-1:0] cnt_q  [NUM_CH];
  logic [RATIO_W-1:0] sh_num [NUM_CH];
  logic [RATIO_W-1:0] sh_den [NUM_CH];
  logic [RATIO_W-1:0] acc_n  [NUM_CH];
  logic [NUM_CH-1:0]  pending;
  logic [NUM_CH-1:0]  en_c;
  logic [NUM_CH-1:0]  wrap;
  logic [NUM_CH-1:0]  apply;
  logic [RATIO_W:0]   s;
  logic               ch_ok;
  logic               cfg_ok;
  logic               xfer;

`ifdef CLK_EN_BURST_MODE_EN
  logic [NUM_CH-1:0]  burst_q;
  logic [NUM_CH-1:0]  sh_burst;
`else
  logic               unused_burst;
  assign unused_burst = cfg_burst;
`endif

  // Out-of-range channels report ready so the request is taken and rejected
  assign ch_ok     = (int'(cfg_ch) < NUM_CH);
  assign cfg_ready = ch_ok ? !pending[cfg_ch] : 1'b1;
  assign cfg_ok    = ch_ok && (cfg_den != '0) && (cfg_num <= cfg_den);
  assign xfer      = cfg_valid && cfg_ready;

  always_comb begin
    s     = '0;
    en_c  = '0;
    wrap  = '0;
    apply = '0;
    acc_n = '{default: '0};
    for (int i = 0; i < NUM_CH; i++) begin
      s        = {1'b0, acc_q[i]} + {1'b0, num_q[i]};
      en_c[i]  = (s >= {1'b0, den_q[i]});
      acc_n[i] = en_c[i] ? RATIO_W'(s - {1'b0, den_q[i]})
                         : s[RATIO_W-1:0];
`ifdef CLK_EN_BURST_MODE_EN
      if (burst_q[i]) begin
        en_c[i]  = (cnt_q[i] < num_q[i]);
        acc_n[i] = '0;
      end
`endif
      wrap[i]  = (cnt_q[i] == den_q[i] - 1'b1);
      apply[i] = pending[i] && (wrap[i] || !run);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_err      <= 1'b0;
      clk_enable   <= '0;
      period_start <= '0;
      pending      <= '0;
`ifdef CLK_EN_BURST_MODE_EN
      burst_q      <= '0;
      sh_burst     <= '0;
`endif
      for (int i = 0; i < NUM_CH; i++) begin
        num_q[i]  <= RATIO_W'(DEF_NUM);
        den_q[i]  <= RATIO_W'(DEF_DEN);
        acc_q[i]  <= '0;
        cnt_q[i]  <= '0;
        sh_num[i] <= '0;
        sh_den[i] <= '0;
      end
    end else begin
      cfg_err <= xfer && !cfg_ok;
      for (int i = 0; i < NUM_CH; i++) begin
        if (run) begin
          clk_enable[i]   <= en_c[i];
          period_start[i] <= (cnt_q[i] == '0);
          acc_q[i]        <= acc_n[i];
          cnt_q[i]        <= wrap[i] ? '0 : cnt_q[i] + 1'b1;
        end else begin
          clk_enable[i]   <= 1'b0;
          period_start[i] <= 1'b0;
          acc_q[i]        <= '0;
          cnt_q[i]        <= '0;
        end
        // New ratio lands on a period boundary so no partial period is emitted
        if (apply[i]) begin
          num_q[i]   <= sh_num[i];
          den_q[i]   <= sh_den[i];
          acc_q[i]   <= '0;
          cnt_q[i]   <= '0;
          pending[i] <= 1'b0;
`ifdef CLK_EN_BURST_MODE_EN
          burst_q[i] <= sh_burst[i];
`endif
        end
        if (xfer && cfg_ok && (cfg_ch == CH_W'(i))) begin
          sh_num[i]  <= cfg_num;
          sh_den[i]  <= cfg_den;
          pending[i] <= 1'b1;
`ifdef CLK_EN_BURST_MODE_EN
          sh_burst[i] <= cfg_burst;
`endif
        end
      end
    end
  end

endmodule
